// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - clock time-set controller: mode FSM, increment strobe with auto-repeat, idle timeout, blink
// Outputs are registered from the next-state/next-value logic so they change on the same edge as the state.
module time_set_ctrl #(
  parameter int HOLD_CYCLES    = 8,
  parameter int REPEAT_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int BLINK_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_mode,
  input  logic btn_inc,
  output logic mode,
  output logic change_hour,
  output logic change_min,
  output logic valid_response,
  output logic blink
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] REPEAT_LAST  = 16'(REPEAT_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] BLINK_LAST   = 16'(BLINK_CYCLES - 1);
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  state_t      state, state_n;
  logic        mode_q, inc_q;
  logic        rep_active, rep_active_n;
  logic        rep_first, rep_first_n;
  logic [15:0] rep_cnt, rep_cnt_n;
  logic [15:0] idle_cnt, idle_cnt_n;
  logic [15:0] blink_cnt, blink_cnt_n;
  logic        blink_n;
  logic        pulse;
  logic        mode_edge, inc_edge;
  logic [15:0] rep_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      mode_q         <= 1'b0;
      inc_q          <= 1'b0;
      rep_active     <= 1'b0;
      rep_first      <= 1'b0;
      rep_cnt        <= 16'd0;
      idle_cnt       <= 16'd0;
      blink_cnt      <= 16'd0;
      mode           <= 1'b0;
      change_hour    <= 1'b0;
      change_min     <= 1'b0;
      valid_response <= 1'b0;
      blink          <= 1'b0;
    end else begin
      state          <= state_n;
      mode_q         <= btn_mode;
      inc_q          <= btn_inc;
      rep_active     <= rep_active_n;
      rep_first      <= rep_first_n;
      rep_cnt        <= rep_cnt_n;
      idle_cnt       <= idle_cnt_n;
      blink_cnt      <= blink_cnt_n;
      mode           <= (state_n != RUN);
      change_hour    <= (state_n == SET_HOUR);
      change_min     <= (state_n == SET_MIN);
      valid_response <= pulse;
      blink          <= blink_n;
    end
  end

  always_comb begin
    state_n      = state;
    rep_active_n = rep_active;
    rep_first_n  = rep_first;
    rep_cnt_n    = rep_cnt;
    idle_cnt_n   = idle_cnt;
    blink_n      = blink;
    blink_cnt_n  = blink_cnt;
    pulse        = 1'b0;
    mode_edge    = btn_mode & ~mode_q;
    inc_edge     = btn_inc & ~inc_q;
    rep_limit    = rep_first ? HOLD_LAST : REPEAT_LAST;

    // Repeat only continues from a pulse started by a real press in this state,
    // so a level held across a state change never fires.
    if (state == RUN) begin
      idle_cnt_n   = 16'd0;
      rep_active_n = 1'b0;
      rep_first_n  = 1'b0;
      rep_cnt_n    = 16'd0;
      if (mode_edge) state_n = SET_HOUR;
    end else if (mode_edge) begin
      state_n      = (state == SET_HOUR) ? SET_MIN : RUN;
      idle_cnt_n   = 16'd0;
      rep_active_n = 1'b0;
      rep_first_n  = 1'b0;
      rep_cnt_n    = 16'd0;
    end else if (btn_inc) begin
      idle_cnt_n = 16'd0;
      if (inc_edge) begin
        pulse        = 1'b1;
        rep_active_n = 1'b1;
        rep_first_n  = 1'b1;
        rep_cnt_n    = 16'd0;
      end else if (rep_active) begin
        if (rep_cnt == rep_limit) begin
          pulse       = 1'b1;
          rep_first_n = 1'b0;
          rep_cnt_n   = 16'd0;
        end else if (rep_cnt != CNT_MAX) begin
          rep_cnt_n = rep_cnt + 16'd1;
        end
      end
    end else begin
      rep_active_n = 1'b0;
      rep_first_n  = 1'b0;
      rep_cnt_n    = 16'd0;
      if (idle_cnt == TIMEOUT_LAST) begin
        state_n    = RUN;
        idle_cnt_n = 16'd0;
      end else if (idle_cnt != CNT_MAX) begin
        idle_cnt_n = idle_cnt + 16'd1;
      end
    end

    // Entering a set state or changing the field restarts the blink phase lit.
    if (state_n == RUN) begin
      blink_n     = 1'b0;
      blink_cnt_n = 16'd0;
    end else if ((state_n != state) || pulse) begin
      blink_n     = 1'b1;
      blink_cnt_n = 16'd0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_n     = ~blink;
      blink_cnt_n = 16'd0;
    end else if (blink_cnt != CNT_MAX) begin
      blink_cnt_n = blink_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - randomized bench for time_set_ctrl against an edge-count reference model
module tb_time_set_ctrl;

  localparam int HOLD    = 8;
  localparam int REPEAT  = 4;
  localparam int TIMEOUT = 64;
  localparam int BLINK   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;
  logic mode, change_hour, change_min, valid_response, blink;

  int total = 0;
  int bad = 0;

  // Reference model state: field index and edge numbers of the events that matter.
  int n = 0;
  int st = 0;
  logic pm = 1'b0, pi = 1'b0;
  logic rep_on = 1'b0;
  int press_edge = 0;
  int last_act = 0;
  int blink_base = 0;
  logic exp_mode = 0, exp_hour = 0, exp_min = 0, exp_valid = 0, exp_blink = 0;

  time_set_ctrl #(
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REPEAT),
    .TIMEOUT_CYCLES(TIMEOUT),
    .BLINK_CYCLES(BLINK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .mode(mode),
    .change_hour(change_hour),
    .change_min(change_min),
    .valid_response(valid_response),
    .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0b expected %0b", tag, n, got, want);
    end
  endtask

  task automatic model(input logic r, input logic bm, input logic bi);
    logic me, ie, pulse;
    int nst, d;
    if (r) begin
      st = 0; pm = 0; pi = 0; rep_on = 0;
      exp_mode = 0; exp_hour = 0; exp_min = 0; exp_valid = 0; exp_blink = 0;
      n++;
      return;
    end
    me = bm && !pm;
    ie = bi && !pi;
    pulse = 0;
    nst = st;
    if (st == 0) begin
      rep_on = 0;
      if (me) nst = 1;
    end else if (me) begin
      nst = (st == 1) ? 2 : 0;
      rep_on = 0;
    end else if (bi) begin
      if (ie) begin
        pulse = 1; rep_on = 1; press_edge = n;
      end else if (rep_on) begin
        d = n - press_edge;
        if (d == HOLD || (d > HOLD && (d - HOLD) % REPEAT == 0)) pulse = 1;
      end
      last_act = n;
    end else begin
      rep_on = 0;
      if (n - last_act == TIMEOUT) nst = 0;
    end
    if (nst != st && nst != 0) begin
      blink_base = n;
      last_act = n;
    end
    if (pulse) blink_base = n;
    st = nst; pm = bm; pi = bi;
    exp_mode  = (st != 0);
    exp_hour  = (st == 1);
    exp_min   = (st == 2);
    exp_valid = pulse;
    exp_blink = (st != 0) && (((n - blink_base) / BLINK) % 2 == 0);
    n++;
  endtask

  task automatic step(input logic r, input logic m, input logic i, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      rst = r; btn_mode = m; btn_inc = i;
      @(posedge clk);
      model(r, m, i);
      #1;
      chk("mode", mode, exp_mode);
      chk("change_hour", change_hour, exp_hour);
      chk("change_min", change_min, exp_min);
      chk("valid_response", valid_response, exp_valid);
      chk("blink", blink, exp_blink);
    end
  endtask

  initial begin
    int kind, len;
    logic m, i;
    step(1, 0, 0, 3);
    // Mode stepping through all three states with gaps.
    step(0, 1, 0, 1); step(0, 0, 0, 5);
    step(0, 1, 0, 1); step(0, 0, 0, 5);
    step(0, 1, 0, 1); step(0, 0, 0, 5);
    // Single press in SET_HOUR, then held press with release in SET_MIN.
    step(0, 1, 0, 1); step(0, 0, 0, 3);
    step(0, 0, 1, 1); step(0, 0, 0, 3);
    step(0, 1, 0, 1); step(0, 0, 0, 2);
    step(0, 0, 1, 21); step(0, 0, 0, 3);
    // Idle until timeout drops back to RUN.
    step(0, 0, 0, 70);
    // Held inc from RUN into SET_HOUR, then simultaneous mode and inc edges.
    step(0, 0, 1, 3); step(0, 1, 1, 1); step(0, 0, 1, 10);
    step(0, 0, 0, 2); step(0, 1, 1, 1); step(0, 0, 1, 12);
    step(0, 0, 0, 1); step(0, 0, 1, 4);
    // Reset mid-repeat with inc still held, and btn_mode held through reset.
    step(0, 0, 1, 15); step(1, 0, 1, 2); step(0, 0, 1, 5);
    step(1, 1, 0, 2); step(0, 1, 0, 3); step(0, 0, 0, 2);

    for (int s = 0; s < 400; s++) begin
      kind = $urandom_range(0, 9);
      m = 1'b0;
      i = 1'b0;
      case (kind)
        0: begin len = $urandom_range(1, 2); step(1, $urandom_range(0, 1), $urandom_range(0, 1), len); end
        1, 2: begin len = $urandom_range(50, 80); step(0, 0, 0, len); end
        3, 4: begin m = 1'b1; i = ($urandom_range(0, 3) == 0); len = $urandom_range(1, 3); step(0, m, i, len); end
        default: begin
          i = 1'b1;
          m = ($urandom_range(0, 7) == 0);
          len = $urandom_range(1, 30);
          step(0, m, i, len);
          len = $urandom_range(1, 4);
          step(0, 0, 0, len);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameters: one per line, as name, default, meaning.
- HOLD_CYCLES, 8: cycles from the first increment pulse to the first auto-repeat pulse.
- REPEAT_CYCLES, 4: cycles between successive auto-repeat pulses.
- TIMEOUT_CYCLES, 64: idle cycles in a set state before returning to RUN.
- BLINK_CYCLES, 16: half-period of the blink output.
- All four are at least 2 and at most 65535; internal counters are 16 bits.
REQ-002 Ports: one per line, as name, direction, width, meaning.
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: reset, synchronous, active-high.
- btn_mode, input, 1: debounced mode button, level.
- btn_inc, input, 1: debounced increment button, level.
- mode, output, 1: 1 while in a set state (SET_HOUR or SET_MIN).
- change_hour, output, 1: 1 while in SET_HOUR.
- change_min, output, 1: 1 while in SET_MIN.
- valid_response, output, 1: single-cycle increment strobe for the selected field.
- blink, output, 1: display blink enable for the selected field.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have exactly three states: RUN, SET_HOUR and SET_MIN.
REQ-005 A mode edge SHALL be btn_mode sampled 1 at the current edge after being sampled 0 at the previous edge; an inc edge is defined the same way on btn_inc.
REQ-006 On a mode edge the FSM SHALL advance RUN -> SET_HOUR -> SET_MIN -> RUN, one step per edge; the new state is visible on outputs from that clock edge.
REQ-007 Output decode SHALL be: mode = (state != RUN); change_hour = (state == SET_HOUR); change_min = (state == SET_MIN).
REQ-008 In a set state, an inc edge with no simultaneous mode edge SHALL assert valid_response for exactly one cycle, starting at the sampling edge.
REQ-009 Auto-repeat: if btn_inc stays 1 after a pulse at edge N, further pulses SHALL occur at N+HOLD_CYCLES, then every REPEAT_CYCLES after that, for as long as btn_inc remains 1.
REQ-010 Auto-repeat SHALL stop on the first cycle btn_inc is sampled 0, with no trailing pulse.
REQ-011 valid_response SHALL never be 1 in RUN, on a mode edge, or in the cycle in which the state changes.
REQ-012 Simultaneous mode edge and inc edge: the mode edge SHALL win, no pulse is generated, and the repeat counter is cleared.
REQ-013 Repeat suppression after a state change:
- If btn_inc is held across a state change, no pulses SHALL occur in the new state until btn_inc is released and pressed again.
- A btn_inc level held from RUN into SET_HOUR SHALL produce no pulse.
REQ-014 Idle counter in a set state:
- It SHALL increment each cycle while btn_inc is sampled 0 and there is no mode edge.
- It SHALL clear to 0 on any pulse, any mode edge, or any cycle with btn_inc = 1.
- It SHALL be held at 0 in RUN.
REQ-015 When the idle counter reaches TIMEOUT_CYCLES-1 and would increment, the FSM SHALL enter RUN at that edge and the counter SHALL clear.
REQ-016 Blink behaviour:
- blink SHALL be 0 in RUN.
- On entry to any set state (including SET_HOUR -> SET_MIN), blink SHALL be set to 1 and its counter cleared.
- blink SHALL then toggle every BLINK_CYCLES cycles while the FSM remains in that state.
REQ-017 Every pulse SHALL force blink to 1 and clear the blink counter, so the field is shown while changing.
REQ-018 Counters SHALL saturate and never wrap; no overflow is reachable within the parameter limits.

Reset
REQ-019 While rst is 1 at a clock edge, the block SHALL set:
- state = RUN;
- all counters = 0;
- edge-detect registers = 0;
- mode = change_hour = change_min = valid_response = blink = 0.
REQ-020 rst SHALL take priority over every other input, including mid-repeat and mid-timeout.
REQ-021 After rst is released, a btn_mode level already held at 1 SHALL count as a mode edge on the first sampled cycle, because the previous sample reset to 0.
REQ-022 Mid-operation reset SHALL abandon any pending pulse; no valid_response occurs in the cycle after reset is released unless a new inc edge is sampled in a set state.

Verification
REQ-023 Reset, then btn_mode pulsed three times with gaps -> mode/change_hour/change_min step through 1/1/0, then 1/0/1, then 0/0/0; valid_response stays 0 throughout.
REQ-024 In SET_HOUR, btn_inc high for 1 cycle at edge 10 -> valid_response high only at edge 10; a downstream hour counter at 23 wraps to 0.
REQ-025 In SET_MIN, btn_inc held from edge 20 to edge 40 (defaults) -> pulses at edges 20, 28, 32, 36, 40; none at 41 after release.
REQ-026 In SET_HOUR with no input activity -> FSM returns to RUN exactly 64 cycles after the last activity; blink toggles at 16-cycle intervals before that, then drops to 0.
REQ-027 btn_mode and btn_inc rising on the same edge in SET_HOUR -> enter SET_MIN, no pulse; holding btn_inc gives no pulse until release and re-press.
REQ-028 rst asserted during auto-repeat in SET_MIN with btn_inc still held -> all outputs 0 the next cycle; RUN after release; no pulses occur.
